// File: rtl/control_sequencer_if.sv
// Control bundle between the microcode sequencer and the CPU datapath.
// The sequencer is the master: it reads opcode/flags and drives every control line.
interface control_sequencer_if;
    logic [3:0] ir_op;
    logic       cf;
    logic       zf;
    logic [2:0] step;
    logic       hlt;
    logic       mi;
    logic       ri;
    logic       ro;
    logic       ii;
    logic       io;
    logic       ai;
    logic       ao;
    logic       bi;
    logic       oi;
    logic       ce;
    logic       co;
    logic       j;
    logic       su;
    logic       eo;
    logic       fi;

    modport master (
        input  ir_op, cf, zf,
        output step, hlt, mi, ri, ro, ii, io, ai, ao, bi, oi, ce, co, j, su, eo, fi
    );

    modport slave (
        output ir_op, cf, zf,
        input  step, hlt, mi, ri, ro, ii, io, ai, ao, bi, oi, ce, co, j, su, eo, fi
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcode step counter and instruction decoder for the 8-bit CPU.
// Control lines are decoded combinationally from the current step, opcode and flags.
module control_sequencer #(
    parameter int MAX_STEPS = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    localparam step_t FINAL_STEP = step_t'(3'(MAX_STEPS - 1));

    step_t      step;
    step_t      last_step;
    logic       halted;
    logic [3:0] op;

    assign op       = bus.ir_op;
    assign bus.step = step;

    // The opcode is only known from T2 onward, so NOP-class opcodes still
    // spend one empty T2 before returning to T0.
    always_comb begin
        last_step = FINAL_STEP;
        if (EARLY_END) begin
            case (op)
                OP_LDA, OP_STA: last_step = T3;
                OP_ADD, OP_SUB: last_step = T4;
                default:        last_step = T2;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            step   <= T0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (step == T2 && op == OP_HLT) begin
                halted <= 1'b1;
            end else if (step >= T2 && step >= last_step) begin
                step <= T0;
            end else begin
                step <= step_t'(step + 3'd1);
            end
        end
    end

    // EO and FI are active-low; the default leaves both deasserted.
    always_comb begin
        bus.hlt = 1'b0;
        bus.mi  = 1'b0;
        bus.ri  = 1'b0;
        bus.ro  = 1'b0;
        bus.ii  = 1'b0;
        bus.io  = 1'b0;
        bus.ai  = 1'b0;
        bus.ao  = 1'b0;
        bus.bi  = 1'b0;
        bus.oi  = 1'b0;
        bus.ce  = 1'b0;
        bus.co  = 1'b0;
        bus.j   = 1'b0;
        bus.su  = 1'b0;
        bus.eo  = 1'b1;
        bus.fi  = 1'b1;
        if (clr) begin
            bus.hlt = 1'b0;
        end else if (halted) begin
            bus.hlt = 1'b1;
        end else begin
            case (step)
                T0: begin
                    bus.co = 1'b1;
                    bus.mi = 1'b1;
                end
                T1: begin
                    bus.ro = 1'b1;
                    bus.ii = 1'b1;
                    bus.ce = 1'b1;
                end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            bus.io = 1'b1;
                            bus.mi = 1'b1;
                        end
                        OP_LDI: begin
                            bus.io = 1'b1;
                            bus.ai = 1'b1;
                        end
                        OP_JMP: begin
                            bus.io = 1'b1;
                            bus.j  = 1'b1;
                        end
                        OP_JC: begin
                            bus.io = bus.cf;
                            bus.j  = bus.cf;
                        end
                        OP_JZ: begin
                            bus.io = bus.zf;
                            bus.j  = bus.zf;
                        end
                        OP_OUT: begin
                            bus.ao = 1'b1;
                            bus.oi = 1'b1;
                        end
                        OP_HLT: bus.hlt = 1'b1;
                        default: bus.hlt = 1'b0;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA: begin
                            bus.ro = 1'b1;
                            bus.ai = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            bus.ro = 1'b1;
                            bus.bi = 1'b1;
                        end
                        OP_STA: begin
                            bus.ao = 1'b1;
                            bus.ri = 1'b1;
                        end
                        default: bus.hlt = 1'b0;
                    endcase
                end
                T4: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        bus.eo = 1'b0;
                        bus.ai = 1'b1;
                        bus.fi = 1'b0;
                        bus.su = (op == OP_SUB);
                    end
                end
                default: bus.hlt = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: two instances (early-end on and off)
// run programs of opcodes against a microcode-table reference model.
module tb_control_sequencer;

    localparam logic [15:0] HLT_B = 16'h8000;
    localparam logic [15:0] MI_B  = 16'h4000;
    localparam logic [15:0] RI_B  = 16'h2000;
    localparam logic [15:0] RO_B  = 16'h1000;
    localparam logic [15:0] II_B  = 16'h0800;
    localparam logic [15:0] IO_B  = 16'h0400;
    localparam logic [15:0] AI_B  = 16'h0200;
    localparam logic [15:0] AO_B  = 16'h0100;
    localparam logic [15:0] BI_B  = 16'h0080;
    localparam logic [15:0] OI_B  = 16'h0040;
    localparam logic [15:0] CE_B  = 16'h0020;
    localparam logic [15:0] CO_B  = 16'h0010;
    localparam logic [15:0] J_B   = 16'h0008;
    localparam logic [15:0] SU_B  = 16'h0004;
    localparam logic [15:0] EO_EN = 16'h0002;
    localparam logic [15:0] FI_EN = 16'h0001;
    localparam logic [15:0] LOW_MASK = 16'h0003;
    localparam int NCYCLES = 3000;

    logic       clk;
    logic       clr_drv [2];
    logic [3:0] op_drv  [2];
    logic       cf_drv  [2];
    logic       zf_drv  [2];
    logic [15:0] act      [2];
    logic [2:0]  act_step [2];

    int         checks;
    int         failures;

    logic [15:0] ucode [16][5];
    logic [5:0]  prog  [256];
    int          mstep   [2];
    bit          mhalt   [2];
    int          haltcnt [2];
    int          pc      [2];
    logic [3:0]  cur_op  [2];
    logic        cur_cf  [2];
    logic        cur_zf  [2];
    bit          mid_done[2];

    control_sequencer_if if_e ();
    control_sequencer_if if_f ();

    assign if_e.ir_op = op_drv[0];
    assign if_e.cf    = cf_drv[0];
    assign if_e.zf    = zf_drv[0];
    assign if_f.ir_op = op_drv[1];
    assign if_f.cf    = cf_drv[1];
    assign if_f.zf    = zf_drv[1];

    control_sequencer #(.MAX_STEPS(5), .EARLY_END(1'b1)) dut_e (
        .clk (clk),
        .clr (clr_drv[0]),
        .bus (if_e.master)
    );

    control_sequencer #(.MAX_STEPS(5), .EARLY_END(1'b0)) dut_f (
        .clk (clk),
        .clr (clr_drv[1]),
        .bus (if_f.master)
    );

    assign act[0] = {if_e.hlt, if_e.mi, if_e.ri, if_e.ro, if_e.ii, if_e.io, if_e.ai, if_e.ao,
                     if_e.bi, if_e.oi, if_e.ce, if_e.co, if_e.j, if_e.su, if_e.eo, if_e.fi};
    assign act[1] = {if_f.hlt, if_f.mi, if_f.ri, if_f.ro, if_f.ii, if_f.io, if_f.ai, if_f.ao,
                     if_f.bi, if_f.oi, if_f.ce, if_f.co, if_f.j, if_f.su, if_f.eo, if_f.fi};
    assign act_step[0] = if_e.step;
    assign act_step[1] = if_f.step;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Microcode written as active-high enables; EO/FI polarity is applied at compare time.
    task automatic build_ucode();
        for (int op = 0; op < 16; op++) begin
            for (int s = 0; s < 5; s++) ucode[op][s] = 16'h0;
            ucode[op][0] = CO_B | MI_B;
            ucode[op][1] = RO_B | II_B | CE_B;
        end
        ucode[1][2]  = IO_B | MI_B;  ucode[1][3] = RO_B | AI_B;
        ucode[2][2]  = IO_B | MI_B;  ucode[2][3] = RO_B | BI_B;  ucode[2][4] = EO_EN | AI_B | FI_EN;
        ucode[3][2]  = IO_B | MI_B;  ucode[3][3] = RO_B | BI_B;  ucode[3][4] = EO_EN | AI_B | SU_B | FI_EN;
        ucode[4][2]  = IO_B | MI_B;  ucode[4][3] = AO_B | RI_B;
        ucode[5][2]  = IO_B | AI_B;
        ucode[6][2]  = IO_B | J_B;
        ucode[7][2]  = IO_B | J_B;
        ucode[8][2]  = IO_B | J_B;
        ucode[14][2] = AO_B | OI_B;
        ucode[15][2] = HLT_B;
    endtask

    // Last populated step of an opcode, never earlier than T2 since the opcode is unknown before then.
    function automatic int last_step_of(input logic [3:0] op);
        int last = 0;
        for (int s = 0; s < 5; s++) if (ucode[op][s] != 16'h0) last = s;
        return (last < 2) ? 2 : last;
    endfunction

    function automatic logic [15:0] expected_ctrl(input int k);
        logic [15:0] w;
        if (clr_drv[k]) w = 16'h0;
        else if (mhalt[k]) w = HLT_B;
        else begin
            w = ucode[op_drv[k]][mstep[k]];
            if (mstep[k] == 2 && ((op_drv[k] == 4'h7 && !cf_drv[k]) || (op_drv[k] == 4'h8 && !zf_drv[k])))
                w = 16'h0;
        end
        return w ^ LOW_MASK;
    endfunction

    task automatic apply_stimulus(input int k, input int cyc);
        logic       clr_v;
        logic [5:0] entry;
        clr_v = (cyc < 2) || (haltcnt[k] >= 10) || (cyc >= 200 && $urandom_range(63) == 0);
        if (!mid_done[k] && !mhalt[k] && cur_op[k] == 4'h2 && mstep[k] == 3) begin
            clr_v = 1'b1;
            mid_done[k] = 1'b1;
        end
        if (!clr_v && !mhalt[k] && mstep[k] == 0) begin
            entry     = prog[pc[k]];
            cur_op[k] = entry[3:0];
            cur_zf[k] = entry[4];
            cur_cf[k] = entry[5];
            pc[k]     = (pc[k] + 1) % 256;
        end
        clr_drv[k] = clr_v;
        op_drv[k]  = (mstep[k] >= 2 && !mhalt[k]) ? cur_op[k] : 4'($urandom);
        cf_drv[k]  = (mstep[k] == 2) ? cur_cf[k] : 1'($urandom);
        zf_drv[k]  = (mstep[k] == 2) ? cur_zf[k] : 1'($urandom);
    endtask

    task automatic update_model(input int k);
        int last;
        if (clr_drv[k]) begin
            mstep[k]   = 0;
            mhalt[k]   = 1'b0;
            haltcnt[k] = 0;
        end else if (mhalt[k]) begin
            haltcnt[k]++;
        end else if (mstep[k] == 2 && op_drv[k] == 4'hF) begin
            mhalt[k]   = 1'b1;
            haltcnt[k] = 0;
        end else if (mstep[k] < 2) begin
            mstep[k]++;
        end else begin
            last     = (k == 0) ? last_step_of(op_drv[k]) : 4;
            mstep[k] = (mstep[k] >= last) ? 0 : mstep[k] + 1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        build_ucode();
        // Directed opening {cf,zf,op}: SUB, JC both ways, JZ both ways, LDI, ADD twice, then the rest.
        prog[0]  = 6'h03; prog[1]  = 6'h07; prog[2]  = 6'h27; prog[3]  = 6'h08;
        prog[4]  = 6'h18; prog[5]  = 6'h05; prog[6]  = 6'h02; prog[7]  = 6'h02;
        prog[8]  = 6'h01; prog[9]  = 6'h04; prog[10] = 6'h06; prog[11] = 6'h0E;
        prog[12] = 6'h00; prog[13] = 6'h0B; prog[14] = 6'h0F; prog[15] = 6'h05;
        for (int i = 16; i < 256; i++) prog[i] = 6'($urandom);
        for (int k = 0; k < 2; k++) begin
            mstep[k] = 0;  mhalt[k] = 1'b0;  haltcnt[k] = 0;  pc[k] = 0;
            cur_op[k] = 4'h0;  cur_cf[k] = 1'b0;  cur_zf[k] = 1'b0;  mid_done[k] = 1'b0;
            clr_drv[k] = 1'b1;  op_drv[k] = 4'h0;  cf_drv[k] = 1'b0;  zf_drv[k] = 1'b0;
        end

        for (int cyc = 0; cyc < NCYCLES; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) apply_stimulus(k, cyc);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (cyc > 0)
                    check_output($sformatf("step lane%0d cyc%0d", k, cyc), 16'(act_step[k]), 16'(mstep[k]));
                check_output($sformatf("ctrl lane%0d cyc%0d op%h", k, cyc, op_drv[k]), act[k], expected_ctrl(k));
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) update_model(k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
